matrix_code_enc: RTL

Streaming encoder for the light-ABFT 4x4 matrix code; it produces the protected form that the matrix-code checker/corrector consumes. It accepts a 4x4 matrix of W-bit elements one element per handshake, in row-major order, and forwards the data. After each row it emits that row's three row-check words; after the fourth row it emits the four column-parity words. It sits between the producer of matrix data and storage or the link feeding the checker.

---
 rtl/matrix_code_enc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_code_enc.sv
// -----------------------------------------------------------------------------
// matrix_code_enc
//   Streaming encoder for the light-ABFT 4x4 matrix code. Accepts a 4x4 matrix
//   of W-bit elements in row-major order, forwards every element, emits three
//   row-check words after each row and four column-parity words after the last
//   row. One block is 32 output words.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   W   matrix element (p11, p12, ..., p44)
//   in_valid   in   1   in_data valid
//   in_ready   out  1   element accepted this cycle when in_valid is also high
//   out_data   out  W   data, row-check or column-parity word
//   out_tag    out  2   0 = data, 1 = row check, 2 = column parity
//   out_valid  out  1   out_data/out_tag/out_last valid
//   out_ready  in   1   sink accepts this cycle
//   out_last   out  1   final word of a block (column parity 4)
// -----------------------------------------------------------------------------
module matrix_code_enc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_ZCHK = 2'd1,
    S_COL  = 2'd2
  } state_t;

  localparam logic [1:0] TAG_DATA = 2'd0;
  localparam logic [1:0] TAG_ROW  = 2'd1;
  localparam logic [1:0] TAG_COL  = 2'd2;

  state_t       state_q, state_d;
  logic [1:0]   row_q, row_d;
  logic [1:0]   col_q, col_d;
  logic [1:0]   k_q, k_d;
  logic [W-1:0] slot_q    [4];
  logic [W-1:0] slot_d    [4];
  logic [W-1:0] col_par_q [4];
  logic [W-1:0] col_par_d [4];

  logic [W-1:0] out_data_d;
  logic [1:0]   out_tag_d;
  logic         out_valid_d;
  logic         out_last_d;

  logic         free;
  logic         accept;
  logic [W-1:0] zword;

  // The output register may load when it is empty or being drained this cycle.
  assign free   = !out_valid || out_ready;
  // Gating with rst_n keeps in_ready low for the whole reset window, not just
  // until the first edge.
  assign in_ready = rst_n && (state_q == S_DATA) && free;
  assign accept   = in_valid && in_ready;

  // Row checks for slots a,b,c,d: z1 = a^b^c, z2 = a^b^d, z3 = a^c^d.
  always_comb begin
    unique case (k_q)
      2'd0:    zword = slot_q[0] ^ slot_q[1] ^ slot_q[2];
      2'd1:    zword = slot_q[0] ^ slot_q[1] ^ slot_q[3];
      default: zword = slot_q[0] ^ slot_q[2] ^ slot_q[3];
    endcase
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    slot_d      = slot_q;
    col_par_d   = col_par_q;
    out_data_d  = out_data;
    out_tag_d   = out_tag;
    out_last_d  = out_last;
    // A word taken by the sink empties the register unless something reloads it.
    out_valid_d = out_valid && !out_ready;

    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          out_data_d        = in_data;
          out_tag_d         = TAG_DATA;
          out_last_d        = 1'b0;
          out_valid_d       = 1'b1;
          slot_d[col_q]     = in_data;
          col_par_d[col_q]  = col_par_q[col_q] ^ in_data;
          col_d             = col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_d = S_ZCHK;
            k_d     = 2'd0;
          end
        end
      end

      S_ZCHK: begin
        if (free) begin
          out_data_d  = zword;
          out_tag_d   = TAG_ROW;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          k_d         = k_q + 2'd1;
          if (k_q == 2'd2) begin
            k_d = 2'd0;
            if (row_q == 2'd3) begin
              state_d = S_COL;
            end else begin
              row_d   = row_q + 2'd1;
              col_d   = 2'd0;
              state_d = S_DATA;
            end
          end
        end
      end

      S_COL: begin
        if (free) begin
          out_data_d  = col_par_q[k_q];
          out_tag_d   = TAG_COL;
          out_last_d  = (k_q == 2'd3);
          out_valid_d = 1'b1;
          k_d         = k_q + 2'd1;
          if (k_q == 2'd3) begin
            // Block complete: the next element starts a fresh matrix.
            for (int i = 0; i < 4; i++) col_par_d[i] = '0;
            row_d   = 2'd0;
            col_d   = 2'd0;
            k_d     = 2'd0;
            state_d = S_DATA;
          end
        end
      end

      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DATA;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      k_q       <= 2'd0;
      out_data  <= '0;
      out_tag   <= TAG_DATA;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      // NOTE: the parity accumulators are reset because a reset mid-block must
      // discard the partial block; a stale parity would corrupt the next one.
      for (int i = 0; i < 4; i++) begin
        slot_q[i]    <= '0;
        col_par_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      out_data  <= out_data_d;
      out_tag   <= out_tag_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      for (int i = 0; i < 4; i++) begin
        slot_q[i]    <= slot_d[i];
        col_par_q[i] <= col_par_d[i];
      end
    end
  end

endmodule
